mdsa_shearsort_idx: RTL and testbench
=====================================

MDSA_SHEARSORT_IDX -- requirements
Module: mdsa_shearsort_idx

Interface
REQ-001 Parameter N, default 4, matrix side; power of two, 2..8.
REQ-002 Parameter W, default 8, element data width, unsigned.
REQ-003 Parameter IW, default 2*log2(N), index width, derived, not overridden.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous assert, active-low (0 = reset), synchronous release.
REQ-006 start  input  1  begin new load; honoured only in IDLE.
REQ-007 dir  input  1  sort direction, sampled with start; 0 ascending, 1 descending.
REQ-008 en  input  1  load strobe; data_in accepted on edges with en=1 while in LOAD.
REQ-009 data_in  input  W  element value.
REQ-010 rdy  output  1  high in LOAD only.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 output_enable  output  1  data_out/idx_out valid this cycle.
REQ-013 data_out  output  W  sorted element.
REQ-014 idx_out  output  IW  original load position (0..N*N-1) of data_out element.

Function
REQ-015 FSM states IDLE, LOAD, ROW, COL, OUT; IDLE->LOAD on start=1, dir latched same edge.
REQ-016 LOAD: k-th accepted beat (k=0..N*N-1) written to cell (k/N, k%N) with tag k; en=0 stalls, no write, count held.
REQ-017 Edge accepting beat N*N-1 moves LOAD->ROW; en and data_in ignored outside LOAD.
REQ-018 ROW phase: exactly N cycles of odd-even transposition on all rows in parallel; step s even compares columns (0,1),(2,3)..., step s odd compares (1,2),(3,4)....
REQ-019 Row order snakelike: dir=0 even rows smaller left, odd rows smaller right; dir=1 inverts both.
REQ-020 COL phase: exactly N cycles, same odd/even step pattern on all columns in parallel; dir=0 smaller on top, dir=1 larger on top.
REQ-021 Swap only on strict inequality; equal values never swap; tag moves with its value.
REQ-022 Phase sequence: (ROW, COL) repeated log2(N)+1 times, then one final ROW; sort total (2*log2(N)+3)*N cycles (28 for N=4).
REQ-023 OUT: N*N consecutive cycles output_enable=1, snake read order: row 0..N-1, even rows column 0..N-1, odd rows column N-1..0.
REQ-024 OUT->IDLE after last element; output_enable deasserted same edge; data_out/idx_out hold last values.
REQ-025 Outputs registered; first output_enable high in cycle after edge E+sort_cycles+1, E = edge accepting last beat.
REQ-026 start while busy=1 ignored, no effect on state, dir or data.
REQ-027 Result: snake-order stream monotonic non-decreasing (dir=0) or non-increasing (dir=1).

Reset
REQ-028 rst=0 forces IDLE immediately, any state, including mid-LOAD/sort/OUT; partial data discarded.
REQ-029 Reset values: rdy=0, busy=0, output_enable=0, data_out=0, idx_out=0, beat/step/phase counters=0, latched dir=0.
REQ-030 After rst release, block idles until start; no output_enable without full new load.

Verification (N=4, W=8)
REQ-031 dir=0, load 15,14,...,0 -> stream data 0..15, idx 15..0; output_enable first high 29 cycles after last-beat edge, 16 cycles wide.
REQ-032 dir=1, load 0..15 -> stream data 15..0, idx 15..0.
REQ-033 all 16 beats value 7, dir=0 -> data all 7, idx 0,1,2,3,7,6,5,4,8,9,10,11,15,14,13,12 (no tie swaps).
REQ-034 load with en low 3 cycles after beat 5, start pulsed during sort -> result identical to contiguous load, second start ignored, busy stays high.
REQ-035 rst=0 at sort step 10 -> all outputs 0 next sample, state IDLE; new load after release sorts correctly per REQ-031.
REQ-036 random 200 matrices, random dir -> stream monotonic, idx_out a permutation of 0..15, data_in[idx_out]==data_out each beat.

Source files
------------

// File: rtl/mdsa_shearsort_idx_if.sv
// Handshake and data bundle for mdsa_shearsort_idx.
//   start/dir      : begin a new load, sort direction (0 asc, 1 desc)
//   en/data_in     : load strobe and element value
//   rdy/busy       : accepting load beats / not idle
//   output_enable  : data_out/idx_out carry a sorted element this cycle
//   data_out       : sorted element value
//   idx_out        : original load position of that element
// master = stimulus side, slave = sorter side.
interface mdsa_shearsort_idx_if #(
  parameter int W  = 8,
  parameter int IW = 4
);
  logic          start;
  logic          dir;
  logic          en;
  logic [W-1:0]  data_in;
  logic          rdy;
  logic          busy;
  logic          output_enable;
  logic [W-1:0]  data_out;
  logic [IW-1:0] idx_out;

  modport master (
    output start, dir, en, data_in,
    input  rdy, busy, output_enable, data_out, idx_out
  );

  modport slave (
    input  start, dir, en, data_in,
    output rdy, busy, output_enable, data_out, idx_out
  );
endinterface

// File: rtl/mdsa_shearsort_idx.sv
// N x N shearsort with index tracking.
// Loads N*N elements row-major, sorts them into snake order with alternating
// row/column odd-even transposition phases, then streams the result in snake
// order together with each element's original load position.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mdsa_shearsort_idx_if.slave (start/dir/en/data_in in,
//          rdy/busy/output_enable/data_out/idx_out out, all registered)
module mdsa_shearsort_idx #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int IW = 2 * $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  mdsa_shearsort_idx_if.slave  bus
);

  localparam int LW  = $clog2(N);
  localparam int NN  = N * N;
  localparam int NPH = LW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, ROW, COL, OUT} state_t;

  state_t        state;
  logic          dir_q;
  logic [IW-1:0] beat;
  logic [LW-1:0] step;
  logic [3:0]    phase;
  logic [IW:0]   ocnt;

  logic [W-1:0]  mat  [N][N];
  logic [IW-1:0] tag  [N][N];
  logic [W-1:0]  nmat [N][N];
  logic [IW-1:0] ntag [N][N];

  logic          rdy;
  logic          busy;
  logic          output_enable;
  logic [W-1:0]  data_out;
  logic [IW-1:0] idx_out;

  logic [LW-1:0] rd_row;
  logic [LW-1:0] rd_col;

  assign bus.rdy           = rdy;
  assign bus.busy          = busy;
  assign bus.output_enable = output_enable;
  assign bus.data_out      = data_out;
  assign bus.idx_out       = idx_out;

  // Snake read address; N is a power of two so N-1-c is simply ~c.
  always_comb begin
    rd_row = ocnt[IW-1:LW];
    rd_col = rd_row[0] ? ~ocnt[LW-1:0] : ocnt[LW-1:0];
  end

  // One transposition step; pairs in a step are disjoint, so every swap
  // reads the pre-step matrix.
  always_comb begin
    nmat = mat;
    ntag = tag;
    if (state == ROW) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N - 1; j++) begin
          if (j[0] == step[0]) begin
            // Smaller-left on even rows for ascending, mirrored otherwise.
            if (((i[0] == 1'b0) ^ dir_q) ? (mat[i][j] > mat[i][j+1])
                                         : (mat[i][j] < mat[i][j+1])) begin
              nmat[i][j]   = mat[i][j+1];
              nmat[i][j+1] = mat[i][j];
              ntag[i][j]   = tag[i][j+1];
              ntag[i][j+1] = tag[i][j];
            end
          end
        end
      end
    end else if (state == COL) begin
      for (int unsigned j = 0; j < N; j++) begin
        for (int unsigned i = 0; i < N - 1; i++) begin
          if (i[0] == step[0]) begin
            if (dir_q ? (mat[i][j] < mat[i+1][j])
                      : (mat[i][j] > mat[i+1][j])) begin
              nmat[i][j]   = mat[i+1][j];
              nmat[i+1][j] = mat[i][j];
              ntag[i][j]   = tag[i+1][j];
              ntag[i+1][j] = tag[i][j];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      dir_q         <= 1'b0;
      beat          <= '0;
      step          <= '0;
      phase         <= '0;
      ocnt          <= '0;
      rdy           <= 1'b0;
      busy          <= 1'b0;
      output_enable <= 1'b0;
      data_out      <= '0;
      idx_out       <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          mat[i][j] <= '0;
          tag[i][j] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= LOAD;
            dir_q <= bus.dir;
            beat  <= '0;
            rdy   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.en) begin
            mat[beat[IW-1:LW]][beat[LW-1:0]] <= bus.data_in;
            tag[beat[IW-1:LW]][beat[LW-1:0]] <= beat;
            if (beat == IW'(NN - 1)) begin
              state <= ROW;
              step  <= '0;
              phase <= '0;
              rdy   <= 1'b0;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        ROW: begin
          mat <= nmat;
          tag <= ntag;
          if (step == LW'(N - 1)) begin
            step <= '0;
            if (phase == 4'(NPH)) begin
              state <= OUT;
              ocnt  <= '0;
            end else begin
              state <= COL;
            end
          end else begin
            step <= step + 1'b1;
          end
        end
        COL: begin
          mat <= nmat;
          tag <= ntag;
          if (step == LW'(N - 1)) begin
            step  <= '0;
            phase <= phase + 1'b1;
            state <= ROW;
          end else begin
            step <= step + 1'b1;
          end
        end
        OUT: begin
          if (ocnt == (IW+1)'(NN)) begin
            output_enable <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            output_enable <= 1'b1;
            data_out      <= mat[rd_row][rd_col];
            idx_out       <= tag[rd_row][rd_col];
            ocnt          <= ocnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdsa_shearsort_idx.sv
// Self-checking bench for mdsa_shearsort_idx (N=4, W=8): a scoreboard queue
// is filled with the expected snake stream when a matrix is loaded and
// drained as output_enable beats appear.
module tb_mdsa_shearsort_idx;

  typedef struct {
    logic [7:0] d;
    logic [3:0] i;
    bit         known;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  int errors = 0;
  int checks = 0;

  exp_t       q[$];
  logic [7:0] ld      [16];
  logic [3:0] exp_idx [16];
  logic [15:0] seen;
  int  last_edge;
  bit  first_pending = 1'b0;
  int  oe_first;
  int  oe_last;

  mdsa_shearsort_idx_if #(.W(8), .IW(4)) bus ();

  mdsa_shearsort_idx #(.N(4), .W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard drain at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.output_enable) begin
      if (q.size() == 0) begin
        check("spurious_oe", bus.output_enable, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (first_pending) begin
          check("first_oe_latency", cyc - last_edge, 29);
          first_pending = 1'b0;
          oe_first = cyc;
        end
        oe_last = cyc;
        check("data_out", bus.data_out, e.d);
        if (e.known) check("idx_out", bus.idx_out, e.i);
        check("idx_ref", ld[bus.idx_out], bus.data_out);
        check("idx_unique", seen[bus.idx_out], 0);
        seen[bus.idx_out] = 1'b1;
      end
    end
  end

  task automatic push_expected(input bit d, input bit use_idx);
    int  v[16];
    int  t;
    bit  distinct;
    exp_t e;
    for (int i = 0; i < 16; i++) v[i] = ld[i];
    for (int a = 0; a < 15; a++) begin
      for (int b = 0; b < 15 - a; b++) begin
        if (d ? (v[b] < v[b+1]) : (v[b] > v[b+1])) begin
          t = v[b]; v[b] = v[b+1]; v[b+1] = t;
        end
      end
    end
    distinct = 1'b1;
    for (int a = 0; a < 16; a++)
      for (int b = a + 1; b < 16; b++)
        if (ld[a] == ld[b]) distinct = 1'b0;
    for (int i = 0; i < 16; i++) begin
      e.d = 8'(v[i]);
      e.known = use_idx || distinct;
      e.i = '0;
      if (use_idx) e.i = exp_idx[i];
      else if (distinct)
        for (int j = 0; j < 16; j++) if (ld[j] == 8'(v[i])) e.i = 4'(j);
      q.push_back(e);
    end
    seen = '0;
  endtask

  task automatic load(input bit d, input bit stall, input bit mid_start);
    int guard = 0;
    while (bus.busy && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("idle_before_start", bus.busy, 0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.dir   = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.dir   = ~d;
    check("rdy_in_load", bus.rdy, 1);
    for (int k = 0; k < 16; k++) begin
      bus.en      = 1'b1;
      bus.data_in = ld[k];
      @(posedge clk); #1;
      if (k == 15) last_edge = cyc;
      bus.en      = 1'b0;
      bus.data_in = 8'($urandom);
      if (stall && k == 5) begin
        repeat (3) begin
          @(posedge clk); #1;
        end
      end
    end
    first_pending = 1'b1;
    check("rdy_after_load", bus.rdy, 0);
    if (mid_start) begin
      repeat (5) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.dir   = ~d;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_hold", bus.busy, 1);
    end
  endtask

  task automatic wait_done();
    int guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    check("drain", q.size(), 0);
    check("oe_width", oe_last - oe_first, 15);
    @(posedge clk); #1;
    check("oe_end", bus.output_enable, 0);
    check("busy_end", bus.busy, 0);
  endtask

  task automatic run(input bit d, input bit use_idx, input bit stall, input bit mid_start);
    push_expected(d, use_idx);
    load(d, stall, mid_start);
    wait_done();
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.dir     = 1'b0;
    bus.en      = 1'b0;
    bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", bus.rdy, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_oe", bus.output_enable, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_idx", bus.idx_out, 0);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_busy", bus.busy, 0);

    // Descending load, ascending sort.
    for (int i = 0; i < 16; i++) ld[i] = 8'(15 - i);
    run(1'b0, 1'b0, 1'b0, 1'b0);

    // Ascending load, descending sort.
    for (int i = 0; i < 16; i++) ld[i] = 8'(i);
    run(1'b1, 1'b0, 1'b0, 1'b0);

    // All-equal values: tags must stay at their load positions.
    begin
      logic [3:0] tie [16] = '{0, 1, 2, 3, 7, 6, 5, 4, 8, 9, 10, 11, 15, 14, 13, 12};
      for (int i = 0; i < 16; i++) begin
        ld[i] = 8'd7;
        exp_idx[i] = tie[i];
      end
    end
    run(1'b0, 1'b1, 1'b0, 1'b0);

    // Stalled load plus a start pulse while sorting.
    for (int i = 0; i < 16; i++) ld[i] = 8'(15 - i);
    run(1'b0, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of the sort.
    for (int i = 0; i < 16; i++) ld[i] = 8'(i * 3 + 1);
    push_expected(1'b0, 1'b0);
    load(1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    first_pending = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rdy", bus.rdy, 0);
    check("mid_rst_oe", bus.output_enable, 0);
    check("mid_rst_data", bus.data_out, 0);
    check("mid_rst_idx", bus.idx_out, 0);
    @(negedge clk) rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_idle", bus.busy, 0);
    for (int i = 0; i < 16; i++) ld[i] = 8'(15 - i);
    run(1'b0, 1'b0, 1'b0, 1'b0);

    // Random matrices, narrow value range on odd trials to force ties.
    for (int t = 0; t < 200; t++) begin
      for (int i = 0; i < 16; i++)
        ld[i] = 8'($urandom_range(0, (t % 2) ? 7 : 255));
      run(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
